serial_parallel: RTL
====================

SERIAL_PARALLEL -- requirements
Module: serial_parallel

Interface
REQ-001 The module SHALL have parameter PARALLEL_PORT_WIDTH, default 15, the width of the parallel output word.
REQ-002 The module SHALL have parameter BIT_LENGTH, default 4, the width of the bit_length port.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port din, input, 1 bit: serial line; idle is released (Z or 1), a 0 is a start bit, data follows MSB first.
REQ-006 Port bit_length, input, BIT_LENGTH bits: number of data bits per frame.
REQ-007 Port rd_ack, input, 1 bit: consumer acknowledge; used only with SERIAL_PARALLEL_HOLD_EN.
REQ-008 Port dout, output, PARALLEL_PORT_WIDTH bits: last received word, right-aligned.
REQ-009 Port dv_out, output, 1 bit: dout valid.
REQ-010 Port busy, output, 1 bit: high while a frame is being received.
REQ-011 Port overflow, output, 1 bit: sticky lost-word flag; tied 0 without SERIAL_PARALLEL_HOLD_EN.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RECEIVE.
REQ-013 In IDLE, a rising edge sampling din == 0 SHALL latch bit_length as L, clear the shift register, load counter = L-1 and enter RECEIVE. Z, X and 1 on din SHALL all count as idle.
REQ-014 If latched L == 0, the FSM SHALL remain in IDLE, and dv_out SHALL NOT assert.
REQ-015 In RECEIVE, each rising edge SHALL shift din into the LSB and decrement the counter, so the first data bit lands at bit L-1.
REQ-016 bit_length changes while in RECEIVE SHALL be ignored until the next start bit.
REQ-017 On the edge where counter == 0, the FSM SHALL:
- load dout with the completed word, upper PARALLEL_PORT_WIDTH-L bits zero;
- set dv_out to 1;
- return to IDLE.
REQ-018 Latency SHALL be as follows: for a start bit sampled at edge E0, dout and dv_out are valid after edge E0+L.
REQ-019 If L > PARALLEL_PORT_WIDTH, only the last PARALLEL_PORT_WIDTH received bits SHALL be kept, and the earlier bits are discarded.
REQ-020 Without SERIAL_PARALLEL_HOLD_EN, dv_out SHALL be a one-cycle pulse, and dout SHALL hold its value until the next completed frame.
REQ-021 A start bit sampled on the edge immediately after frame completion SHALL be accepted, giving back-to-back frames with no gap cycle required.
REQ-022 busy SHALL equal (state == RECEIVE).

Reset
REQ-023 When rstn is low, the module SHALL immediately set all of the following, aborting any frame in progress and emitting no partial word:
- state = IDLE;
- dout = 0;
- dv_out = 0;
- busy = 0;
- overflow = 0;
- counter = 0;
- shift register = 0.

Configuration
REQ-024 With macro SERIAL_PARALLEL_HOLD_EN defined, dv_out SHALL stay high from frame completion until the rising edge on which rd_ack == 1 is sampled.
REQ-025 With SERIAL_PARALLEL_HOLD_EN defined, a frame that completes while dv_out is still high SHALL:
- overwrite dout;
- keep dv_out high;
- set overflow, which is cleared only by reset.
REQ-026 With SERIAL_PARALLEL_HOLD_EN defined, if rd_ack and a frame completion coincide on the same edge, completion SHALL win: dv_out stays 1, and overflow is not set.
REQ-027 With SERIAL_PARALLEL_HOLD_EN undefined, the module SHALL ignore rd_ack and SHALL tie overflow to 0.

Structure
REQ-028 Package serial_pkg SHALL hold the FSM state encodings (IDLE, RECEIVE) and the default values of PARALLEL_PORT_WIDTH and BIT_LENGTH. The parallel_serial transmitter SHALL share this package.
REQ-029 The block SHALL be a single module with no sub-module; the shift register and counter are inline.

Verification
REQ-030 L=4, din = 0,1,0,1,1 on consecutive edges SHALL give dout = 0x000B, with dv_out high for exactly one cycle after the 5th edge.
REQ-031 L=15, start bit then word 0x2A5A sent MSB first SHALL give dout = 0x2A5A; changing bit_length to 3 mid-frame SHALL have no effect on the result.
REQ-032 L=0 with din = 0 for one cycle SHALL leave busy = 0 and dv_out = 0 throughout.
REQ-033 L=4, rstn pulsed low after the 2nd data bit SHALL set all outputs to 0 immediately. A subsequent full frame 0,1,1,1,1 SHALL then give dout = 0x000F.
REQ-034 Two back-to-back L=4 frames, 0x9 then 0x6, with the second start bit on the edge after completion, SHALL produce two dv_out pulses, with dout = 0x9 and then dout = 0x6.
REQ-035 With SERIAL_PARALLEL_HOLD_EN defined and two frames sent with no rd_ack, the bench SHALL observe:
- dv_out held high;
- dout equal to the second word;
- overflow = 1.
A single rd_ack then SHALL drop dv_out on the next edge.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial_parallel receiver and the parallel_serial
// transmitter: FSM state encoding and default port widths.
package serial_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } sp_state_e;

  localparam int PARALLEL_PORT_WIDTH_DEF = 15;
  localparam int BIT_LENGTH_DEF          = 4;

endpackage

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver.
// A 0 sampled on an idle line is a start bit. bit_length data bits then
// follow, MSB first. The completed word is right-aligned on dout, and
// dv_out flags it.
// Optional macro SERIAL_PARALLEL_HOLD_EN: with it, dv_out holds until rd_ack
// is sampled, and overflow records any word that was overwritten before it
// was read.
module serial_parallel
  import serial_pkg::*;
#(
  parameter int PARALLEL_PORT_WIDTH = PARALLEL_PORT_WIDTH_DEF,
  parameter int BIT_LENGTH          = BIT_LENGTH_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din,
  input  logic [BIT_LENGTH-1:0]          bit_length,
  input  logic                           rd_ack,
  output logic [PARALLEL_PORT_WIDTH-1:0] dout,
  output logic                           dv_out,
  output logic                           busy,
  output logic                           overflow
);

  sp_state_e                      state;
  sp_state_e                      state_nxt;
  logic [BIT_LENGTH-1:0]          cnt;
  logic [PARALLEL_PORT_WIDTH-1:0] shreg;
  logic [PARALLEL_PORT_WIDTH-1:0] word_nxt;
  logic                           start;
  logic                           done;

  // A start bit is a clean 0. Z, X and 1 leave the compare false.
  assign start    = (state == IDLE) && (din == 1'b0);
  assign done     = (state == RECEIVE) && (cnt == '0);
  // Only the newest PARALLEL_PORT_WIDTH bits survive a long frame.
  assign word_nxt = {shreg[PARALLEL_PORT_WIDTH-2:0], din};
  assign busy     = (state == RECEIVE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-length frame never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (bit_length != '0)) state_nxt = RECEIVE;
      RECEIVE: if (cnt == '0)                   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter. The length is captured only at the start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (start) begin
      cnt   <= bit_length - 1'b1;
      shreg <= '0;
    end else if (state == RECEIVE) begin
      cnt   <= cnt - 1'b1;
      shreg <= word_nxt;
    end
  end

`ifdef SERIAL_PARALLEL_HOLD_EN
  // Output word, held valid flag and sticky overflow. A completion outranks a
  // coincident acknowledge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dv_out   <= 1'b0;
      overflow <= 1'b0;
    end else if (done) begin
      dout   <= word_nxt;
      dv_out <= 1'b1;
      if (dv_out && !rd_ack) overflow <= 1'b1;
    end else if (rd_ack) begin
      dv_out <= 1'b0;
    end
  end
`else
  logic unused_rd_ack;
  assign unused_rd_ack = rd_ack;
  assign overflow      = 1'b0;

  // Output word, held until the next frame, with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout   <= '0;
      dv_out <= 1'b0;
    end else begin
      dv_out <= done;
      if (done) dout <= word_nxt;
    end
  end
`endif

endmodule
